branch_repair_issuer: RTL and testbench

- Back-end producer of the predictor update/repair interface that the global-history table and IJTC consume.
- Collects resolved branches from two branch units per cycle and compares them against the front-end prediction.
- Queues training (direct) and repair records and issues one record per cycle to the predictors over a valid/ready handshake.
- Tracks the wrong-path window after a mispredict so younger resolutions are discarded.

---
 rtl/branch_repair_issuer_pkg.sv | 30 +++
 rtl/branch_repair_issuer_repair_fifo.sv | 57 +++++
 rtl/branch_repair_issuer.sv | 169 ++++++++++++++++
 tb/tb_branch_repair_issuer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_repair_issuer_pkg.sv
// Shared definitions for the branch repair issuer.
// Holds the repair action encodings, default checkpoint/action widths,
// the issuer FSM state type and the per-lane branch classification helper.
package branch_repair_issuer_pkg;

  localparam int CKPT_W_DEF = 8;
  localparam int ACT_W_DEF  = 2;

  localparam logic [1:0] REPAIR_NONE   = 2'b00;
  localparam logic [1:0] REPAIR_DIRECT = 2'b01;
  localparam logic [1:0] REPAIR_DIR    = 2'b10;
  localparam logic [1:0] REPAIR_DEST   = 2'b11;

  typedef enum logic {
    ST_NORMAL     = 1'b0,
    ST_WAIT_FLUSH = 1'b1
  } issuer_state_e;

  // Direction mismatch has priority; a target mismatch only matters when
  // both prediction and outcome are taken.
  function automatic logic [1:0] classify(input logic        pred_take,
                                          input logic        take,
                                          input logic [31:0] pred_dest,
                                          input logic [31:0] dest);
    if (pred_take != take) return REPAIR_DIR;
    if (take && (pred_dest != dest)) return REPAIR_DEST;
    return REPAIR_DIRECT;
  endfunction

endpackage

// File: rtl/branch_repair_issuer_repair_fifo.sv
// Two-write / one-read synchronous FIFO holding issuer records.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   wr0_en/wr0_data     first (older) write port
//   wr1_en/wr1_data     second (younger) write port; lands behind port 0
//                       when both are enabled, at the tail otherwise
//   rd_en               pop the head
//   rd_data             head entry (combinational read)
//   count               registered occupancy, 0..DEPTH
//   empty               no entries
// The caller never writes more entries than there are free slots.
module branch_repair_issuer_repair_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr0_en,
  input  logic [W-1:0]               wr0_data,
  input  logic                       wr1_en,
  input  logic [W-1:0]               wr1_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit: equal low bits with differing MSB means full,
  // fully equal pointers mean empty.
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic [AW:0]  wr1_ptr;
  logic [W-1:0] mem [DEPTH];

  assign wr1_ptr = wptr + (AW+1)'(wr0_en);
  assign count   = wptr - rptr;
  assign empty   = (wptr == rptr);
  assign rd_data = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr + (AW+1)'(wr0_en) + (AW+1)'(wr1_en);
      rptr <= rptr + (AW+1)'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (wr0_en) mem[wptr[AW-1:0]]    <= wr0_data;
    if (wr1_en) mem[wr1_ptr[AW-1:0]] <= wr1_data;
  end

endmodule

// File: rtl/branch_repair_issuer.sv
// Branch repair issuer: classifies resolved branches from two branch units,
// queues training (DIRECT) and repair records and issues them one per cycle
// to the predictors. After a repair is queued, younger resolutions are
// discarded until the flush completes.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   bju0_* / bju1_*          resolved branch, lane0 older than lane1
//   flush_i                  flush done for the outstanding mispredict
//   stall_o                  no free queue slot
//   rp_*                     record output channel
//   dropCnt_o                saturating count of dropped DIRECT records
//   fsm_state                current issuer state (observation)
// Record channel: rp_valid_o/rp_ready_i is a plain valid/ready handshake;
// a record transfers on a cycle where both are high, and the record
// fields hold stable while valid is high and ready is low. When valid is
// low every rp_* field reads zero.
module branch_repair_issuer
  import branch_repair_issuer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int CKPT_W = CKPT_W_DEF,
  parameter int ACT_W  = ACT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bju0_valid_i,
  input  logic [31:0]       bju0_vaddr_i,
  input  logic              bju0_predTake_i,
  input  logic [31:0]       bju0_predDest_i,
  input  logic              bju0_take_i,
  input  logic [31:0]       bju0_dest_i,
  input  logic [CKPT_W-1:0] bju0_checkPoint_i,
  input  logic              bju1_valid_i,
  input  logic [31:0]       bju1_vaddr_i,
  input  logic              bju1_predTake_i,
  input  logic [31:0]       bju1_predDest_i,
  input  logic              bju1_take_i,
  input  logic [31:0]       bju1_dest_i,
  input  logic [CKPT_W-1:0] bju1_checkPoint_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              rp_valid_o,
  input  logic              rp_ready_i,
  output logic [ACT_W-1:0]  rp_action_o,
  output logic [CKPT_W-1:0] rp_checkPoint_o,
  output logic [31:0]       rp_erroVAddr_o,
  output logic              rp_correctTake_o,
  output logic [31:0]       rp_correctDest_o,
  output logic [15:0]       dropCnt_o,
  output issuer_state_e     fsm_state
);

  localparam int REC_W = ACT_W + CKPT_W + 32 + 1 + 32;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  issuer_state_e    state, state_next;
  logic [1:0]       cls0, cls1;
  logic             rep0, rep1;
  logic [REC_W-1:0] rec0, rec1, head, head_g;
  logic [CNT_W-1:0] count, free, free_after0;
  logic             empty, accept;
  logic             enq0, enq1, drop0, drop1;
  logic [15:0]      drop_cnt;
  logic [16:0]      drop_sum;

  // ---- classification and record build ----
  assign cls0 = classify(bju0_predTake_i, bju0_take_i, bju0_predDest_i, bju0_dest_i);
  assign cls1 = classify(bju1_predTake_i, bju1_take_i, bju1_predDest_i, bju1_dest_i);
  assign rep0 = (cls0 != REPAIR_DIRECT);
  assign rep1 = (cls1 != REPAIR_DIRECT);

  // Not-taken branches train/repair toward the fall-through PC+8.
  assign rec0 = {ACT_W'(cls0), bju0_checkPoint_i, bju0_vaddr_i, bju0_take_i,
                 bju0_take_i ? bju0_dest_i : bju0_vaddr_i + 32'd8};
  assign rec1 = {ACT_W'(cls1), bju1_checkPoint_i, bju1_vaddr_i, bju1_take_i,
                 bju1_take_i ? bju1_dest_i : bju1_vaddr_i + 32'd8};

  // Space is judged on the registered count only; a same-cycle pop does
  // not make room.
  assign free    = CNT_W'(DEPTH) - count;
  assign stall_o = (free == '0);
  assign accept  = (state == ST_NORMAL) && !stall_o;

  // ---- FSM: state register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_NORMAL;
    else      state <= state_next;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_next = state;
    case (state)
      ST_NORMAL: begin
        // A lane0 repair makes lane1 wrong-path, but either lane's repair
        // opens the wrong-path window.
        if (accept && ((bju0_valid_i && rep0) || (bju1_valid_i && rep1)))
          state_next = ST_WAIT_FLUSH;
      end
      ST_WAIT_FLUSH: begin
        if (flush_i) state_next = ST_NORMAL;
      end
      default: state_next = ST_NORMAL;
    endcase
  end

  // ---- FSM: outputs (enqueue / drop decisions) ----
  // The last free slot is kept for a repair, so a DIRECT needs two free
  // slots counting any lane0 write made this cycle. A repair therefore
  // always finds a slot whenever the queue is not full.
  always_comb begin
    enq0        = 1'b0;
    enq1        = 1'b0;
    drop0       = 1'b0;
    drop1       = 1'b0;
    free_after0 = free;
    if (accept) begin
      if (bju0_valid_i) begin
        if (rep0 || (free >= CNT_W'(2))) enq0  = 1'b1;
        else                             drop0 = 1'b1;
      end
      free_after0 = free - CNT_W'(enq0);
      if (bju1_valid_i && !(bju0_valid_i && rep0)) begin
        if (rep1 || (free_after0 >= CNT_W'(2))) enq1  = 1'b1;
        else                                    drop1 = 1'b1;
      end
    end
  end

  assign fsm_state = state;

  // ---- drop counter ----
  assign drop_sum = {1'b0, drop_cnt} + 17'(drop0) + 17'(drop1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             drop_cnt <= '0;
    else if (drop_sum[16]) drop_cnt <= 16'hFFFF;
    else                   drop_cnt <= drop_sum[15:0];
  end

  assign dropCnt_o = drop_cnt;

  // ---- record queue ----
  branch_repair_issuer_repair_fifo #(
    .W     (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr0_en   (enq0),
    .wr0_data (rec0),
    .wr1_en   (enq1),
    .wr1_data (rec1),
    .rd_en    (rp_valid_o && rp_ready_i),
    .rd_data  (head),
    .count    (count),
    .empty    (empty)
  );

  // ---- output channel ----
  assign rp_valid_o       = !empty;
  assign head_g           = rp_valid_o ? head : '0;
  assign rp_correctDest_o = head_g[31:0];
  assign rp_correctTake_o = head_g[32];
  assign rp_erroVAddr_o   = head_g[64:33];
  assign rp_checkPoint_o  = head_g[65 +: CKPT_W];
  assign rp_action_o      = head_g[REC_W-1 -: ACT_W];

endmodule

// File: tb/tb_branch_repair_issuer.sv
// Directed testbench for branch_repair_issuer (DEPTH=4, CKPT_W=8, ACT_W=2).
module tb_branch_repair_issuer;
  import branch_repair_issuer_pkg::*;

  localparam int DEPTH  = 4;
  localparam int CKPT_W = 8;
  localparam int ACT_W  = 2;
  localparam int REC_W  = ACT_W + CKPT_W + 65;

  logic              clk;
  logic              rst;
  logic              bju0_valid_i, bju1_valid_i;
  logic [31:0]       bju0_vaddr_i, bju1_vaddr_i;
  logic              bju0_predTake_i, bju1_predTake_i;
  logic [31:0]       bju0_predDest_i, bju1_predDest_i;
  logic              bju0_take_i, bju1_take_i;
  logic [31:0]       bju0_dest_i, bju1_dest_i;
  logic [CKPT_W-1:0] bju0_checkPoint_i, bju1_checkPoint_i;
  logic              flush_i;
  logic              stall_o;
  logic              rp_valid_o;
  logic              rp_ready_i;
  logic [ACT_W-1:0]  rp_action_o;
  logic [CKPT_W-1:0] rp_checkPoint_o;
  logic [31:0]       rp_erroVAddr_o;
  logic              rp_correctTake_o;
  logic [31:0]       rp_correctDest_o;
  logic [15:0]       dropCnt_o;
  issuer_state_e     fsm_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [REC_W-1:0] exp_q[$];

  branch_repair_issuer #(.DEPTH(DEPTH), .CKPT_W(CKPT_W), .ACT_W(ACT_W)) dut (
    .clk(clk), .rst(rst),
    .bju0_valid_i(bju0_valid_i), .bju0_vaddr_i(bju0_vaddr_i),
    .bju0_predTake_i(bju0_predTake_i), .bju0_predDest_i(bju0_predDest_i),
    .bju0_take_i(bju0_take_i), .bju0_dest_i(bju0_dest_i),
    .bju0_checkPoint_i(bju0_checkPoint_i),
    .bju1_valid_i(bju1_valid_i), .bju1_vaddr_i(bju1_vaddr_i),
    .bju1_predTake_i(bju1_predTake_i), .bju1_predDest_i(bju1_predDest_i),
    .bju1_take_i(bju1_take_i), .bju1_dest_i(bju1_dest_i),
    .bju1_checkPoint_i(bju1_checkPoint_i),
    .flush_i(flush_i), .stall_o(stall_o),
    .rp_valid_o(rp_valid_o), .rp_ready_i(rp_ready_i),
    .rp_action_o(rp_action_o), .rp_checkPoint_o(rp_checkPoint_o),
    .rp_erroVAddr_o(rp_erroVAddr_o), .rp_correctTake_o(rp_correctTake_o),
    .rp_correctDest_o(rp_correctDest_o), .dropCnt_o(dropCnt_o),
    .fsm_state(fsm_state)
  );

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1);
  end

  // ---- checking ----
  task automatic check(input string tag, input logic [79:0] actual, input logic [79:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [REC_W-1:0] mk_rec(input logic [1:0] act, input logic [7:0] ck,
                                              input logic [31:0] vaddr, input logic take,
                                              input logic [31:0] cdest);
    return {act, ck, vaddr, take, cdest};
  endfunction

  function automatic logic [REC_W-1:0] rp_rec();
    return {rp_action_o, rp_checkPoint_o, rp_erroVAddr_o, rp_correctTake_o, rp_correctDest_o};
  endfunction

  // ---- drivers ----
  task automatic drive_lane(input int lane, input logic [31:0] vaddr, input logic pt,
                            input logic [31:0] pd, input logic tk, input logic [31:0] d,
                            input logic [7:0] ck);
    if (lane == 0) begin
      bju0_valid_i = 1'b1; bju0_vaddr_i = vaddr; bju0_predTake_i = pt;
      bju0_predDest_i = pd; bju0_take_i = tk; bju0_dest_i = d; bju0_checkPoint_i = ck;
    end else begin
      bju1_valid_i = 1'b1; bju1_vaddr_i = vaddr; bju1_predTake_i = pt;
      bju1_predDest_i = pd; bju1_take_i = tk; bju1_dest_i = d; bju1_checkPoint_i = ck;
    end
  endtask

  task automatic idle_lanes();
    bju0_valid_i = 1'b0;
    bju1_valid_i = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
  endtask

  // ---- stimulus ----
  initial begin
    int sent, got, cyc, pend;
    logic held;
    logic [REC_W-1:0] held_rec;
    logic [31:0] va, dd;

    rst = 1'b0; flush_i = 1'b0; rp_ready_i = 1'b0;
    idle_lanes();
    bju0_vaddr_i = '0; bju0_predTake_i = 0; bju0_predDest_i = '0; bju0_take_i = 0;
    bju0_dest_i = '0; bju0_checkPoint_i = '0;
    bju1_vaddr_i = '0; bju1_predTake_i = 0; bju1_predDest_i = '0; bju1_take_i = 0;
    bju1_dest_i = '0; bju1_checkPoint_i = '0;

    // Reset values
    #12;
    check("rst_valid", rp_valid_o, 0);
    check("rst_action", rp_action_o, 0);
    check("rst_rec", rp_rec(), 0);
    check("rst_drop", dropCnt_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_state", fsm_state, ST_NORMAL);
    rst = 1'b1;
    step();

    // Lane0 correct, lane1 REPAIR_DIR
    rp_ready_i = 1'b1;
    drive_lane(0, 32'h1000, 1, 32'h2000, 1, 32'h2000, 8'h11);
    drive_lane(1, 32'h1008, 0, 32'h0,    1, 32'h3000, 8'h12);
    step();
    idle_lanes();
    check("a_head0", rp_rec(), mk_rec(2'b01, 8'h11, 32'h1000, 1, 32'h2000));
    check("a_state", fsm_state, ST_WAIT_FLUSH);
    drive_lane(0, 32'h5000, 1, 32'h5000, 1, 32'h5000, 8'h55);  // must be ignored
    step();
    check("a_head1", rp_rec(), mk_rec(2'b10, 8'h12, 32'h1008, 1, 32'h3000));
    step();
    check("a_ignored", rp_valid_o, 0);
    check("a_none", rp_action_o, 0);
    idle_lanes();
    do_flush();
    check("a_back_normal", fsm_state, ST_NORMAL);

    // Lane0 REPAIR_DEST discards lane1
    rp_ready_i = 1'b0;
    drive_lane(0, 32'h4000, 1, 32'h2000, 1, 32'h2040, 8'h21);
    drive_lane(1, 32'h4008, 0, 32'h0,    0, 32'h0,    8'h22);
    step();
    idle_lanes();
    check("b_head", rp_rec(), mk_rec(2'b11, 8'h21, 32'h4000, 1, 32'h2040));
    check("b_state", fsm_state, ST_WAIT_FLUSH);
    step();
    check("b_hold", rp_rec(), mk_rec(2'b11, 8'h21, 32'h4000, 1, 32'h2040));
    rp_ready_i = 1'b1;
    step();
    check("b_lane1_gone", rp_valid_o, 0);
    do_flush();

    // Reservation of the last slot
    rp_ready_i = 1'b0;
    drive_lane(0, 32'h6000, 0, 32'h0, 0, 32'hdead, 8'h31);
    drive_lane(1, 32'h6004, 1, 32'h7000, 1, 32'h7000, 8'h32);
    step();
    idle_lanes();
    drive_lane(0, 32'h6008, 0, 32'h0, 0, 32'hdead, 8'h33);
    step();
    check("c_stall_3", stall_o, 0);
    check("c_drop_0", dropCnt_o, 0);
    drive_lane(0, 32'h600c, 0, 32'h0, 0, 32'hdead, 8'h34);  // needs 2 free, only 1
    step();
    check("c_drop_1", dropCnt_o, 1);
    check("c_stall_after_drop", stall_o, 0);
    drive_lane(0, 32'h6010, 1, 32'h9999, 0, 32'hdead, 8'h35);  // REPAIR_DIR
    step();
    idle_lanes();
    check("c_stall_full", stall_o, 1);
    check("c_state", fsm_state, ST_WAIT_FLUSH);
    do_flush();
    drive_lane(0, 32'h6020, 0, 32'h0, 0, 32'h0, 8'h36);  // ignored while stalled
    drive_lane(1, 32'h6024, 0, 32'h0, 0, 32'h0, 8'h37);
    step();
    idle_lanes();
    check("c_stall_ignored_drop", dropCnt_o, 1);
    check("c_stall_ignored_state", fsm_state, ST_NORMAL);
    exp_q.push_back(mk_rec(2'b01, 8'h31, 32'h6000, 0, 32'h6008));
    exp_q.push_back(mk_rec(2'b01, 8'h32, 32'h6004, 1, 32'h7000));
    exp_q.push_back(mk_rec(2'b01, 8'h33, 32'h6008, 0, 32'h6010));
    exp_q.push_back(mk_rec(2'b10, 8'h35, 32'h6010, 0, 32'h6018));
    rp_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("c_drain", rp_rec(), exp_q.pop_front());
      step();
    end
    check("c_empty", rp_valid_o, 0);

    // Backpressure with random ready over 20 DIRECT records
    sent = 0; got = 0; cyc = 0; held = 1'b0; held_rec = '0;
    rp_ready_i = 1'b0;
    while ((sent < 20 || got < 20) && cyc < 1000) begin
      if (held) check("d_stable", rp_rec(), held_rec);
      rp_ready_i = 1'($urandom_range(0, 1));
      pend = 0;
      held = 1'b0;
      if (rp_valid_o) begin
        if (rp_ready_i) begin
          if (exp_q.size() == 0) check("d_extra", rp_rec(), 0);
          else check("d_order", rp_rec(), exp_q.pop_front());
          got++;
          pend = 1;
        end else begin
          held = 1'b1;
          held_rec = rp_rec();
        end
      end
      idle_lanes();
      if (sent < 20 && (DEPTH - (exp_q.size() + pend)) >= 2) begin
        va = 32'h8000 + 32'(sent) * 16;
        if (sent % 3 != 0) begin
          dd = 32'h9000 + 32'(sent) * 4;
          drive_lane(0, va, 1, dd, 1, dd, 8'(8'h40 + sent));
          exp_q.push_back(mk_rec(2'b01, 8'(8'h40 + sent), va, 1, dd));
        end else begin
          drive_lane(0, va, 0, 32'h0, 0, 32'hbad0, 8'(8'h40 + sent));
          exp_q.push_back(mk_rec(2'b01, 8'(8'h40 + sent), va, 0, va + 32'd8));
        end
        sent++;
      end
      step();
      cyc++;
    end
    idle_lanes();
    check("d_count", got, 20);
    check("d_drops_none", dropCnt_o, 1);
    check("d_empty", rp_valid_o, 0);

    // Drop counter saturation
    rst = 1'b0; #2; rst = 1'b1;
    rp_ready_i = 1'b0;
    exp_q.delete();
    drive_lane(0, 32'hA000, 0, 32'h0, 0, 32'h0, 8'h01);
    drive_lane(1, 32'hA004, 0, 32'h0, 0, 32'h0, 8'h02);
    step();
    bju1_valid_i = 1'b0;
    step();  // queue now holds 3
    bju1_valid_i = 1'b1;
    step();
    check("e_two_drops", dropCnt_o, 2);
    repeat (32766) @(posedge clk);
    #1;
    check("e_near_sat", dropCnt_o, 16'hFFFE);
    bju1_valid_i = 1'b0;
    step();
    check("e_sat", dropCnt_o, 16'hFFFF);
    bju1_valid_i = 1'b1;
    step();
    check("e_sat_hold", dropCnt_o, 16'hFFFF);
    idle_lanes();

    // Asynchronous reset while entries are pending
    check("f_pending", rp_valid_o, 1);
    rst = 1'b0;
    #1;
    check("f_rst_valid", rp_valid_o, 0);
    check("f_rst_drop", dropCnt_o, 0);
    check("f_rst_action", rp_action_o, 0);
    #2;
    rst = 1'b1;
    rp_ready_i = 1'b1;
    step();
    check("f_empty_after", rp_valid_o, 0);
    check("f_stall_after", stall_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
